// File: rtl/jtframe_lfbuf_ddr_arb_pkg.sv
// Shared types and constants for the line-frame-buffer DDR arbiter.
package jtframe_lfbuf_pkg;

  localparam int unsigned LFBUF_AW    = 29;
  localparam int unsigned LFBUF_BURST = 64;
  localparam logic [7:0]  LFBUF_BE    = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GAP,
    ST_RD_CMD,
    ST_RD_DATA,
    ST_WR_DATA
  } arb_state_e;

endpackage

// File: rtl/jtframe_lfbuf_ddr_arb_if.sv
// DDR burst port shared by the line buffer: the arbiter is master, the memory is slave.
interface jtframe_lfbuf_ddr_arb_if
  import jtframe_lfbuf_pkg::*;
#(
  parameter int unsigned AW = LFBUF_AW,
  parameter int unsigned BW = 8
);

  logic          ddram_clk;
  logic          ddram_busy;
  logic [BW-1:0] ddram_burstcnt;
  logic [AW-1:0] ddram_addr;
  logic          ddram_rd;
  logic [63:0]   ddram_dout;
  logic          ddram_dout_ready;
  logic          ddram_we;
  logic [63:0]   ddram_din;
  logic [7:0]    ddram_be;

  modport master (
    output ddram_clk, ddram_burstcnt, ddram_addr, ddram_rd, ddram_we, ddram_din, ddram_be,
    input  ddram_busy, ddram_dout, ddram_dout_ready
  );

  modport slave (
    input  ddram_clk, ddram_burstcnt, ddram_addr, ddram_rd, ddram_we, ddram_din, ddram_be,
    output ddram_busy, ddram_dout, ddram_dout_ready
  );

endinterface

// File: rtl/jtframe_lfbuf_ddr_beatcnt.sv
// Burst beat counter: saturates at LIMIT, flags the final beat and the full burst.
module jtframe_lfbuf_ddr_beatcnt #(
  parameter int unsigned LIMIT = 64,
  parameter int unsigned CW    = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o,
  output logic tc_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)              cnt_d = '0;
    else if (en_i && !tc_o) cnt_d = cnt_q + 1'b1;
  end

  assign last_o = (cnt_q == CW'(LIMIT - 1));
  assign tc_o   = (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/jtframe_lfbuf_ddr_arb.sv
// Arbiter between a line-fetch reader and a line-store writer sharing one DDR
// burst port; one full burst per grant, followed by a single idle gap cycle.
module jtframe_lfbuf_ddr_arb
  import jtframe_lfbuf_pkg::*;
#(
  parameter int unsigned AW    = LFBUF_AW,
  parameter int unsigned BURST = LFBUF_BURST,
  parameter int unsigned BW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_ack,
  output logic [63:0]   rd_dout,
  output logic          rd_valid,
  output logic          rd_done,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [63:0]   wr_din,
  output logic          wr_ack,
  output logic          wr_pull,
  output logic          wr_done,
  jtframe_lfbuf_ddr_arb_if.master ddr
);

  localparam int unsigned CW = $clog2(BURST + 1);

  arb_state_e    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [63:0]   rd_dout_q, rd_dout_d;
  logic          rd_ack_q, rd_ack_d, wr_ack_q, wr_ack_d;
  logic          rd_q, rd_d, we_q, we_d;
  logic          rd_valid_q, rd_valid_d, rd_done_q, rd_done_d, wr_done_q, wr_done_d;
  logic          last_rd_q, last_rd_d;
  logic          cnt_clr, cnt_en, cnt_last, cnt_tc, grant_rd;

  jtframe_lfbuf_ddr_beatcnt #(.LIMIT(BURST), .CW(CW)) u_beatcnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .last_o (cnt_last),
    .tc_o   (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rd_dout_q  <= '0;
      rd_ack_q   <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_q       <= 1'b0;
      we_q       <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_done_q  <= 1'b0;
      wr_done_q  <= 1'b0;
      last_rd_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rd_dout_q  <= rd_dout_d;
      rd_ack_q   <= rd_ack_d;
      wr_ack_q   <= wr_ack_d;
      rd_q       <= rd_d;
      we_q       <= we_d;
      rd_valid_q <= rd_valid_d;
      rd_done_q  <= rd_done_d;
      wr_done_q  <= wr_done_d;
      last_rd_q  <= last_rd_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rd_dout_d  = rd_dout_q;
    rd_ack_d   = 1'b0;
    wr_ack_d   = 1'b0;
    rd_d       = rd_q;
    we_d       = we_q;
    rd_valid_d = 1'b0;
    rd_done_d  = 1'b0;
    wr_done_d  = 1'b0;
    last_rd_d  = last_rd_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    // Read wins a tie unless it was the one served last.
    grant_rd   = rd_req && (!wr_req || !last_rd_q);
    case (state_q)
      ST_IDLE: begin
        if (grant_rd) begin
          state_d   = ST_RD_CMD;
          addr_d    = rd_addr;
          rd_ack_d  = 1'b1;
          rd_d      = 1'b1;
          last_rd_d = 1'b1;
        end else if (wr_req) begin
          state_d   = ST_WR_DATA;
          addr_d    = wr_addr;
          wr_ack_d  = 1'b1;
          we_d      = 1'b1;
          last_rd_d = 1'b0;
        end
      end
      ST_GAP: state_d = ST_IDLE;
      ST_RD_CMD: begin
        if (!ddr.ddram_busy) begin
          rd_d    = 1'b0;
          state_d = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        // Once saturated, the final rd_valid has been issued; done follows it.
        if (cnt_tc) begin
          rd_done_d = 1'b1;
          cnt_clr   = 1'b1;
          state_d   = ST_GAP;
        end else begin
          rd_valid_d = ddr.ddram_dout_ready;
          rd_dout_d  = ddr.ddram_dout;
          cnt_en     = ddr.ddram_dout_ready;
        end
      end
      ST_WR_DATA: begin
        cnt_en = wr_pull;
        if (wr_pull && cnt_last) begin
          we_d      = 1'b0;
          wr_done_d = 1'b1;
          cnt_clr   = 1'b1;
          state_d   = ST_GAP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rd_ack   = rd_ack_q;
  assign rd_dout  = rd_dout_q;
  assign rd_valid = rd_valid_q;
  assign rd_done  = rd_done_q;
  assign wr_ack   = wr_ack_q;
  assign wr_pull  = we_q & ~ddr.ddram_busy;
  assign wr_done  = wr_done_q;

  assign ddr.ddram_clk      = clk;
  assign ddr.ddram_burstcnt = BW'(BURST);
  assign ddr.ddram_addr     = addr_q;
  assign ddr.ddram_rd       = rd_q;
  assign ddr.ddram_we       = we_q;
  assign ddr.ddram_din      = wr_din;
  assign ddr.ddram_be       = LFBUF_BE;

endmodule

// File: tb/tb_jtframe_lfbuf_ddr_arb.sv
// Randomized bench for jtframe_lfbuf_ddr_arb against a behavioural DDR/arbitration model.
module tb_jtframe_lfbuf_ddr_arb;
  import jtframe_lfbuf_pkg::*;

  localparam int unsigned AW    = 29;
  localparam int unsigned BW    = 8;
  localparam int unsigned BURST = 64;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          rd_req = 1'b0, wr_req = 1'b0;
  logic [AW-1:0] rd_addr = '0, wr_addr = '0;
  logic [63:0]   wr_din = '0;
  logic          rd_ack, rd_valid, rd_done, wr_ack, wr_pull, wr_done;
  logic [63:0]   rd_dout;
  logic          busy = 1'b0, ready = 1'b0;
  logic [63:0]   dout = '0;

  jtframe_lfbuf_ddr_arb_if #(.AW(AW), .BW(BW)) ddr ();

  assign ddr.ddram_busy       = busy;
  assign ddr.ddram_dout       = dout;
  assign ddr.ddram_dout_ready = ready;

  jtframe_lfbuf_ddr_arb #(.AW(AW), .BURST(BURST), .BW(BW)) dut (
    .clk (clk), .rst_n (rst_n),
    .rd_req (rd_req), .rd_addr (rd_addr), .rd_ack (rd_ack), .rd_dout (rd_dout),
    .rd_valid (rd_valid), .rd_done (rd_done),
    .wr_req (wr_req), .wr_addr (wr_addr), .wr_din (wr_din), .wr_ack (wr_ack),
    .wr_pull (wr_pull), .wr_done (wr_done),
    .ddr (ddr)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0, n_errors = 0;
  int unsigned cyc = 0;
  int unsigned busy_mode = 0, busy_cnt = 0;
  bit          stray_en = 1'b0, check_gap = 1'b0;
  int unsigned rd_hold = 0, wr_hold = 0;
  bit          rd_drop_pend = 1'b0, wr_drop_pend = 1'b0;
  int unsigned rq[$];
  logic [AW-1:0] rq_addr = '0;
  int unsigned ret_wait = 0;
  int unsigned wr_seed = 0;
  logic [AW-1:0] exp_addr = '0;
  bit          active = 1'b0;
  bit          grant_log[$];
  int unsigned n_rd_hi, n_we_hi, n_rd_done, n_wr_done, n_pull, n_valid, wr_idx;
  int unsigned rd_valid_cnt, n_rd_ack, n_wr_ack;
  int unsigned last_done_cyc, last_valid_cyc, last_pull_cyc;
  int unsigned addr_bad = 0, overlap = 0, pull_bad = 0, rd_bad = 0, wr_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ddr_word(input logic [AW-1:0] a, input int unsigned i);
    return {3'b101, a, 32'(i)};
  endfunction

  function automatic logic [63:0] wr_word(input int unsigned i);
    return {wr_seed ^ (i * 32'h9E37_79B9), 32'(i)};
  endfunction

  task automatic clear_stats();
    n_rd_hi = 0; n_we_hi = 0; n_rd_done = 0; n_wr_done = 0; n_pull = 0; n_valid = 0;
    wr_idx = 0; rd_valid_cnt = 0; n_rd_ack = 0; n_wr_ack = 0;
    last_done_cyc = 0; last_valid_cyc = 0; last_pull_cyc = 0;
    grant_log.delete(); active = 1'b0;
  endtask

  // One clock: drive the DDR side and wr_din, then observe and score the cycle.
  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    busy = 1'b0;
    if (ddr.ddram_rd && busy_cnt > 0) begin
      busy = 1'b1;
      busy_cnt--;
    end else if (busy_mode == 1) busy = 1'($urandom_range(0, 1));
    else if (busy_mode == 2)     busy = cyc[0];
    ready = 1'b0;
    dout  = {$urandom, $urandom};
    if (ret_wait > 0) ret_wait--;
    else if (rq.size() > 0 && $urandom_range(0, 3) != 0) begin
      ready = 1'b1;
      dout  = ddr_word(rq_addr, rq.pop_front());
    end
    if (!ready && stray_en && $urandom_range(0, 1) == 1) ready = 1'b1;
    wr_din = wr_word(wr_idx);
    #1;
    if (rd_drop_pend) begin rd_req = 1'b0; rd_drop_pend = 1'b0; end
    if (wr_drop_pend) begin wr_req = 1'b0; wr_drop_pend = 1'b0; end
    if (rd_ack && wr_ack) overlap++;
    if (rd_ack || wr_ack) begin
      if (check_gap && last_done_cyc != 0) check("gap", cyc - last_done_cyc, 2);
      grant_log.push_back(rd_ack);
      exp_addr = rd_ack ? rd_addr : wr_addr;
      active   = 1'b1;
      if (rd_ack) begin n_rd_ack++; if (rd_hold == 1) rd_drop_pend = 1'b1; end
      if (wr_ack) begin n_wr_ack++; if (wr_hold == 1) wr_drop_pend = 1'b1; end
    end
    if (ddr.ddram_rd) n_rd_hi++;
    if (ddr.ddram_we) n_we_hi++;
    if (ddr.ddram_rd && ddr.ddram_we) overlap++;
    if (wr_pull !== (ddr.ddram_we && !busy)) pull_bad++;
    if (active && ddr.ddram_addr !== exp_addr) addr_bad++;
    if (ddr.ddram_rd && !busy) begin
      for (int unsigned k = 0; k < BURST; k++) rq.push_back(k);
      rq_addr  = ddr.ddram_addr;
      ret_wait = $urandom_range(1, 4);
    end
    if (rd_valid) begin
      if (rd_dout !== ddr_word(exp_addr, n_valid)) rd_bad++;
      n_valid++; rd_valid_cnt++; last_valid_cyc = cyc;
    end
    if (wr_pull) begin
      if (ddr.ddram_din !== wr_word(wr_idx)) wr_bad++;
      wr_idx++; n_pull++; last_pull_cyc = cyc;
    end
    if (rd_done) begin
      n_rd_done++;
      check("rd_beats", n_valid, BURST);
      check("rd_done_lat", cyc - last_valid_cyc, 1);
      n_valid = 0; active = 1'b0; last_done_cyc = cyc;
      if (rd_hold == 0) rd_req = 1'b0;
    end
    if (wr_done) begin
      n_wr_done++;
      check("wr_beats", wr_idx, BURST);
      check("wr_done_lat", cyc - last_pull_cyc, 1);
      check("we_at_done", ddr.ddram_we, 0);
      wr_idx = 0; active = 1'b0; last_done_cyc = cyc;
      if (wr_hold == 0) wr_req = 1'b0;
    end
  endtask

  task automatic wait_for_done(input int unsigned target, input int unsigned budget, input string tag);
    int unsigned n = 0;
    while (n_rd_done + n_wr_done < target && n < budget) begin tick(); n++; end
    if (n_rd_done + n_wr_done < target) check(tag, n_rd_done + n_wr_done, target);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rd_req = 1'b0; wr_req = 1'b0; active = 1'b0;
    rq.delete(); ret_wait = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    clear_stats();
  endtask

  bit          model_last_rd;
  bit          exp_seq[4];
  bit          exp_rd;
  int unsigned n, g0, d0, kind;

  initial begin
    wr_seed = $urandom;
    clear_stats();
    // Reset state
    repeat (3) tick();
    check("rst_ctrl", {rd_ack, rd_valid, rd_done, wr_ack, wr_done, ddr.ddram_rd, ddr.ddram_we}, 0);
    check("rst_addr", ddr.ddram_addr, 0);
    check("rst_dout", rd_dout, 0);
    check("rst_pull", wr_pull, 0);
    check("burstcnt", ddr.ddram_burstcnt, BURST);
    check("byte_en", ddr.ddram_be, 8'hFF);
    check("ddram_clk", ddr.ddram_clk, clk);
    rst_n = 1'b1;
    clear_stats();
    model_last_rd = 1'b0;

    // Test 1: read with three busy cycles at command time
    busy_mode = 0; busy_cnt = 3; rd_hold = 0; rd_addr = AW'(32'h100);
    rd_req = 1'b1;
    wait_for_done(1, 500, "t1_timeout");
    repeat (8) tick();
    check("t1_rd_cycles", n_rd_hi, 4);
    check("t1_valid", rd_valid_cnt, BURST);
    check("t1_done", n_rd_done, 1);
    check("t1_no_we", n_we_hi, 0);
    check("t1_acks", n_rd_ack, 1);
    model_last_rd = 1'b1;

    // Test 2: write with busy toggling, stray read-data strobes ignored
    clear_stats();
    busy_mode = 2; stray_en = 1'b1; wr_hold = 0; wr_addr = AW'(32'h200);
    wr_req = 1'b1;
    wait_for_done(1, 500, "t2_timeout");
    repeat (8) tick();
    stray_en = 1'b0;
    check("t2_pulls", n_pull, BURST);
    check("t2_done", n_wr_done, 1);
    check("t2_no_rd", n_rd_hi, 0);
    check("t2_no_valid", rd_valid_cnt, 0);
    check("t2_acks", n_wr_ack, 1);

    // Test 3: both requests held from reset -> strict alternation
    do_reset();
    model_last_rd = 1'b0;
    for (int k = 0; k < 4; k++) begin exp_seq[k] = !model_last_rd; model_last_rd = exp_seq[k]; end
    busy_mode = 1; rd_hold = 2; wr_hold = 2; check_gap = 1'b1;
    rd_addr = AW'($urandom); wr_addr = AW'($urandom);
    rd_req = 1'b1; wr_req = 1'b1;
    n = 0;
    while (grant_log.size() < 4 && n < 2000) begin tick(); n++; end
    rd_req = 1'b0; wr_req = 1'b0;
    wait_for_done(4, 600, "t3_timeout");
    repeat (6) tick();
    check_gap = 1'b0;
    check("t3_ngrants", grant_log.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < grant_log.size()) check("t3_order", grant_log[k], exp_seq[k]);

    // Test 4: reset at beat 30 of a write
    clear_stats();
    busy_mode = 1; wr_hold = 0; wr_addr = AW'($urandom);
    wr_req = 1'b1;
    n = 0;
    while (n_pull < 30 && n < 500) begin tick(); n++; end
    check("t4_reached_30", n_pull, 30);
    rst_n = 1'b0; wr_req = 1'b0; active = 1'b0;
    tick();
    check("t4_we_after_rst", ddr.ddram_we, 0);
    check("t4_pull_after_rst", wr_pull, 0);
    rst_n = 1'b1; wr_idx = 0;
    repeat (100) tick();
    check("t4_no_done", n_wr_done, 0);
    rd_hold = 0; rd_addr = AW'($urandom);
    rd_req = 1'b1;
    wait_for_done(1, 600, "t4_timeout");
    check("t4_next_read", n_rd_done, 1);
    model_last_rd = 1'b1;

    // Test 5: read-data strobes while idle
    clear_stats();
    stray_en = 1'b1;
    repeat (20) tick();
    stray_en = 1'b0;
    check("t5_no_valid", rd_valid_cnt, 0);

    // Test 6: read request dropped right after its ack
    clear_stats();
    busy_mode = 1; rd_hold = 1; rd_addr = AW'($urandom);
    rd_req = 1'b1;
    wait_for_done(1, 600, "t6_timeout");
    repeat (6) tick();
    check("t6_done", n_rd_done, 1);
    check("t6_valid", rd_valid_cnt, BURST);
    check("t6_acks", n_rd_ack, 1);
    model_last_rd = 1'b1;

    // Random mix of single and contended requests
    rd_hold = 2; wr_hold = 2;
    for (int it = 0; it < 6; it++) begin
      kind = $urandom_range(0, 2);
      exp_rd = (kind == 0) ? 1'b1 : (kind == 1) ? 1'b0 : !model_last_rd;
      rd_addr = AW'($urandom); wr_addr = AW'($urandom);
      busy_mode = $urandom_range(0, 1);
      g0 = grant_log.size(); d0 = n_rd_done + n_wr_done;
      rd_req = (kind != 1); wr_req = (kind != 0);
      n = 0;
      while (grant_log.size() == g0 && n < 300) begin tick(); n++; end
      rd_req = 1'b0; wr_req = 1'b0;
      if (grant_log.size() == g0) check("t7_grant_timeout", grant_log.size(), g0 + 1);
      else check("t7_grant", grant_log[grant_log.size() - 1], exp_rd);
      model_last_rd = exp_rd;
      wait_for_done(d0 + 1, 600, "t7_timeout");
      repeat (2) tick();
    end

    check("addr_const", addr_bad, 0);
    check("rd_we_overlap", overlap, 0);
    check("pull_rule", pull_bad, 0);
    check("rd_data", rd_bad, 0);
    check("wr_data", wr_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/jtframe_lfbuf_ddr_arb.md
JTFRAME_LFBUF_DDR_ARB -- requirements
Module: jtframe_lfbuf_ddr_arb

Interface
REQ-001 Parameter AW, default 29: DDR word address width.
REQ-002 Parameter BURST, default 64: 64-bit beats per burst (one 256-pixel, 16-bit line).
REQ-003 Parameter BW, default 8: burst count width.
REQ-004 clk  in  1  single clock; all logic is on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 rd_req  in  1  line-fetch request, level.
REQ-007 rd_addr  in  AW  line-fetch start address, stable while rd_req is high.
REQ-008 rd_ack  out  1  one-cycle pulse: fetch granted.
REQ-009 rd_dout  out  64  fetched beat.
REQ-010 rd_valid  out  1  rd_dout is valid this cycle.
REQ-011 rd_done  out  1  one-cycle pulse after the last fetched beat.
REQ-012 wr_req  in  1  line-store request, level.
REQ-013 wr_addr  in  AW  line-store start address, stable while wr_req is high.
REQ-014 wr_din  in  64  current beat to store.
REQ-015 wr_ack  out  1  one-cycle pulse: store granted.
REQ-016 wr_pull  out  1  current wr_din beat was accepted; present the next beat in the following cycle.
REQ-017 wr_done  out  1  one-cycle pulse after the last stored beat.
REQ-018 ddram_clk  out  1  equals clk.
REQ-019 ddram_busy  in  1  DDR wait-request.
REQ-020 ddram_burstcnt  out  BW  constant BURST.
REQ-021 ddram_addr  out  AW  burst start address.
REQ-022 ddram_rd  out  1  read command.
REQ-023 ddram_dout  in  64  read data.
REQ-024 ddram_dout_ready  in  1  read data valid.
REQ-025 ddram_we  out  1  write beat strobe.
REQ-026 ddram_din  out  64  write data; combinational copy of wr_din.
REQ-027 ddram_be  out  8  constant 8'hFF.

Function
REQ-028 The FSM SHALL have five states: IDLE, GAP, RD_CMD, RD_DATA and WR_DATA.
REQ-029 In IDLE with only one request high, that requester SHALL be granted: ack pulses in the grant cycle and ddram_addr latches its address.
REQ-030 With both requests high, the grant SHALL go to the requester not served last; after reset, read wins.
REQ-031 RD_CMD SHALL hold ddram_rd=1 until the first cycle with ddram_busy=0, then drop ddram_rd and move to RD_DATA.
REQ-032 In RD_DATA, rd_dout and rd_valid SHALL be ddram_dout and ddram_dout_ready registered with one-cycle latency; a 7-bit beat counter SHALL count ddram_dout_ready.
REQ-033 After beat BURST, rd_done SHALL pulse in the cycle after the last rd_valid, and the FSM SHALL go to GAP.
REQ-034 WR_DATA SHALL hold ddram_we=1; a beat SHALL be accepted in each cycle with ddram_busy=0, and wr_pull SHALL equal ddram_we & ~ddram_busy.
REQ-035 After BURST accepted beats, ddram_we SHALL drop in the next cycle, wr_done SHALL pulse in that cycle, and the FSM SHALL go to GAP.
REQ-036 GAP SHALL last exactly one cycle and ignore requests, so that a req still high in the cycle after done is not re-granted; it then SHALL return to IDLE.
REQ-037 ddram_dout_ready SHALL be ignored outside RD_DATA, and ddram_busy SHALL be ignored in IDLE and GAP.
REQ-038 ddram_rd and ddram_we SHALL never be high in the same cycle.
REQ-039 ddram_addr SHALL remain constant from grant to done.
REQ-040 A request dropped after its ack SHALL NOT abort the burst; the burst SHALL complete.
REQ-041 The beat counter SHALL saturate and clear at the transition to GAP, so a BURST-beat burst never wraps.

Reset
REQ-042 While rst_n=0 at a clock edge: FSM=IDLE, beat counter=0, last-served=write (so read wins next).
REQ-043 While rst_n=0 at a clock edge, all registered outputs SHALL be 0: rd_ack, rd_valid, rd_done, wr_ack, wr_done, ddram_rd, ddram_we, ddram_addr, rd_dout.
REQ-044 Reset mid-burst SHALL abandon the burst silently: no done pulse, and no DDR strobe in the cycle after reset.

Structure
REQ-045 A shared package jtframe_lfbuf_pkg SHALL hold the state enum, BURST, the default AW and the 8'hFF byte-enable constant.
REQ-046 One sub-module, jtframe_lfbuf_ddr_beatcnt, SHALL implement the beat counter with clear, enable and terminal-count output; everything else SHALL be flat.

Verification
REQ-047 Test 1: rd_req with rd_addr=0x100, ddram_busy held at 1 for 3 cycles -> ddram_rd high for 4 cycles with ddram_addr=0x100, then 64 rd_valid beats matching a DDR model, then one rd_done.
REQ-048 Test 2: wr_req with wr_addr=0x200, busy toggling every other cycle -> exactly 64 wr_pull pulses, each write beat equals wr_din, wr_done once, ddram_rd stays 0.
REQ-049 Test 3: rd_req and wr_req high in the same IDLE cycle, both held -> grant order read, write, read, write, with one GAP cycle between bursts.
REQ-050 Test 4: rst_n=0 at beat 30 of a write -> next cycle ddram_we=0, wr_done never pulses, the next request is served normally.
REQ-051 Test 5: ddram_dout_ready pulses while in IDLE -> no rd_valid.
REQ-052 Test 6: rd_req dropped one cycle after rd_ack -> full 64-beat burst and rd_done still occur.
